// File: rtl/bf16_fp32_pkg.sv
// Shared constants and state encoding for the BF16 <-> FP32 packing blocks.
//   BF16_W, FP32_W : element widths
//   PACK_LANES     : BF16 lanes per 128-bit packed word
//   BF16_EXP_MAX   : all-ones BF16 exponent (Inf / NaN)
//   state_e        : widening-stream controller states
package bf16_fp32_pkg;

  localparam int unsigned BF16_W       = 16;
  localparam int unsigned FP32_W       = 32;
  localparam int unsigned PACK_LANES   = 8;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } state_e;

endpackage

// File: rtl/bf16_2_fp32_lane.sv
// Single-lane combinational BF16 -> FP32 widening.
//   bf16   : input BF16 value
//   fp32   : widened FP32 value (optional flush-to-zero / NaN quieting)
//   is_nan : input is a NaN (exponent all ones, mantissa non-zero)
module bf16_2_fp32_lane
  import bf16_fp32_pkg::*;
#(
  parameter bit FTZ  = 1'b0,
  parameter bit QNAN = 1'b1
) (
  input  logic [BF16_W-1:0] bf16,
  output logic [FP32_W-1:0] fp32,
  output logic              is_nan
);

  logic       sign;
  logic [7:0] expo;
  logic [6:0] mant;

  assign sign = bf16[15];
  assign expo = bf16[14:7];
  assign mant = bf16[6:0];

  assign is_nan = (expo == BF16_EXP_MAX) && (mant != 7'd0);

  always_comb begin
    fp32 = {bf16, 16'h0000};
    if (FTZ && (expo == 8'd0) && (mant != 7'd0)) begin
      fp32 = {sign, 31'b0};
    end else if (QNAN && is_nan) begin
      // Quiet bit is the top FP32 mantissa bit.
      fp32[22] = 1'b1;
    end
  end

endmodule

// File: rtl/bf16_2_fp32_stream.sv
// Streaming BF16 -> FP32 widening unit.
// Captures a 128-bit word of eight BF16 lanes and replays it as 8/OUT_LANES
// FP32 beats of OUT_LANES lanes each (lowest lane in the low bits).
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : bf16_in holds a packed word
//   in_ready   : word can be accepted this cycle
//   bf16_in    : lane i at [16i+15:16i]
//   out_valid  : fp32_out holds a beat
//   out_ready  : consumer takes the beat
//   fp32_out   : lane j at [32j+31:32j]
//   out_last   : final beat of the current word
//   nan_seen   : sticky, set once any accepted beat carried a NaN lane
module bf16_2_fp32_stream
  import bf16_fp32_pkg::*;
#(
  parameter int unsigned OUT_LANES = 4,
  parameter bit          FTZ       = 1'b0,
  parameter bit          QNAN      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PACK_LANES*BF16_W-1:0] bf16_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FP32_W*OUT_LANES-1:0] fp32_out,
  output logic                        out_last,
  output logic                        nan_seen
);

  localparam int unsigned Beats  = PACK_LANES / OUT_LANES;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned SliceW = OUT_LANES * BF16_W;
  localparam int unsigned WordW  = PACK_LANES * BF16_W;

  state_e              state_q, state_d;
  logic [WordW-1:0]    hold_q, hold_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                nan_q, nan_d;

  logic                beat_hs;
  logic                in_hs;
  logic [SliceW-1:0]   beat_slice;
  logic [OUT_LANES-1:0] lane_nan;

  assign out_valid = (state_q == StDrain);
  assign out_last  = out_valid && (beat_q == BeatW'(Beats - 1));
  assign beat_hs   = out_valid && out_ready;
  // Refill in the same cycle the last beat leaves, so back-to-back words have no bubble.
  assign in_ready  = !rst && ((state_q == StIdle) || (beat_hs && out_last));
  assign in_hs     = in_valid && in_ready;
  assign nan_seen  = nan_q;

  assign beat_slice = hold_q[32'(beat_q) * SliceW +: SliceW];

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    bf16_2_fp32_lane #(
      .FTZ  (FTZ),
      .QNAN (QNAN)
    ) u_lane (
      .bf16   (beat_slice[j*BF16_W +: BF16_W]),
      .fp32   (fp32_out[j*FP32_W +: FP32_W]),
      .is_nan (lane_nan[j])
    );
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          state_d = StDrain;
          hold_d  = bf16_in;
          beat_d  = '0;
        end
      end
      StDrain: begin
        if (beat_hs) begin
          if (out_last) begin
            if (in_hs) begin
              hold_d = bf16_in;
              beat_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            beat_d = (Beats > 1) ? beat_q + BeatW'(1) : '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign nan_d = nan_q || (beat_hs && (|lane_nan));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      beat_q  <= '0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      beat_q  <= beat_d;
      nan_q   <= nan_d;
    end
  end

endmodule

// File: tb/tb_bf16_2_fp32_stream.sv
// Self-checking bench for bf16_2_fp32_stream (OUT_LANES=4).
// Two instances share all stimulus: dut_a (FTZ=0, QNAN=1) and dut_b (FTZ=1, QNAN=0).
// Reference: a queue of pending BF16 lanes plus a per-value conversion function.
module tb_bf16_2_fp32_stream;

  localparam int unsigned OL = 4;
  localparam int unsigned OW = 32 * OL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [127:0]  bf16_in = '0;

  logic          in_ready_a, out_valid_a, out_last_a, nan_a;
  logic          in_ready_b, out_valid_b, out_last_b, nan_b;
  logic [OW-1:0] fp32_a, fp32_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]   lanes[$];
  bit            nan_m    = 1'b0;
  bit            accepted = 1'b0;
  bit            lit_en   = 1'b0;
  bit            zero_chk = 1'b0;
  logic [OW-1:0] lit_a, lit_b;

  logic [15:0] specials [10] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h0001,
                                 16'h8001, 16'h7F81, 16'hFFC0, 16'h007F, 16'h3F80};

  always #5 clk = ~clk;

  bf16_2_fp32_stream #(.OUT_LANES(OL), .FTZ(1'b0), .QNAN(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .bf16_in   (bf16_in),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .fp32_out  (fp32_a),
    .out_last  (out_last_a),
    .nan_seen  (nan_a)
  );

  bf16_2_fp32_stream #(.OUT_LANES(OL), .FTZ(1'b1), .QNAN(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .bf16_in   (bf16_in),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .fp32_out  (fp32_b),
    .out_last  (out_last_b),
    .nan_seen  (nan_b)
  );

  function automatic bit ref_is_nan(logic [15:0] x);
    logic [7:0] ex;
    logic [6:0] mt;
    ex = x[14:7];
    mt = x[6:0];
    return (ex == 8'd255) && (mt != 7'd0);
  endfunction

  function automatic logic [31:0] ref_conv(logic [15:0] x, bit ftz, bit qnan);
    logic [7:0]  ex;
    logic [6:0]  mt;
    logic [31:0] r;
    ex = x[14:7];
    mt = x[6:0];
    r  = {x, 16'h0000};
    if (ftz && ex == 8'd0 && mt != 7'd0) r = x[15] ? 32'h8000_0000 : 32'h0000_0000;
    else if (qnan && ref_is_nan(x)) r = r | 32'h0040_0000;
    return r;
  endfunction

  function automatic logic [15:0] rand_lane();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 9)];
    return 16'($urandom);
  endfunction

  function automatic logic [127:0] rand_word();
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[16*i +: 16] = rand_lane();
    return w;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; checks at the falling edge, then advances the model.
  task automatic step();
    bit            ev, el, er, any_nan;
    logic [OW-1:0] ea, eb;
    @(negedge clk);
    ev = (lanes.size() != 0);
    el = (lanes.size() == OL);
    er = !ev || (out_ready && el);
    ea = '0;
    eb = '0;
    any_nan = 1'b0;
    if (ev) begin
      for (int j = 0; j < OL; j++) begin
        ea[32*j +: 32] = ref_conv(lanes[j], 1'b0, 1'b1);
        eb[32*j +: 32] = ref_conv(lanes[j], 1'b1, 1'b0);
        if (ref_is_nan(lanes[j])) any_nan = 1'b1;
      end
    end
    if (rst) begin
      chk("in_ready_during_rst_a", 128'(in_ready_a), 128'(0));
      chk("in_ready_during_rst_b", 128'(in_ready_b), 128'(0));
    end else begin
      chk("out_valid_a", 128'(out_valid_a), 128'(ev));
      chk("out_valid_b", 128'(out_valid_b), 128'(ev));
      chk("in_ready_a", 128'(in_ready_a), 128'(er));
      chk("in_ready_b", 128'(in_ready_b), 128'(er));
      chk("nan_seen_a", 128'(nan_a), 128'(nan_m));
      chk("nan_seen_b", 128'(nan_b), 128'(nan_m));
      if (ev) begin
        chk("fp32_out_a", 128'(fp32_a), 128'(ea));
        chk("fp32_out_b", 128'(fp32_b), 128'(eb));
        chk("out_last_a", 128'(out_last_a), 128'(el));
        chk("out_last_b", 128'(out_last_b), 128'(el));
        if (lit_en) begin
          chk("literal_beat_a", 128'(fp32_a), 128'(lit_a));
          chk("literal_beat_b", 128'(fp32_b), 128'(lit_b));
          lit_en = 1'b0;
        end
      end else if (zero_chk) begin
        chk("reset_fp32_out_a", 128'(fp32_a), 128'(0));
        chk("reset_fp32_out_b", 128'(fp32_b), 128'(0));
        chk("reset_out_last_a", 128'(out_last_a), 128'(0));
        zero_chk = 1'b0;
      end
    end
    @(posedge clk);
    accepted = 1'b0;
    if (rst) begin
      lanes.delete();
      nan_m = 1'b0;
    end else begin
      if (ev && out_ready) begin
        if (any_nan) nan_m = 1'b1;
        repeat (OL) void'(lanes.pop_front());
      end
      if (in_valid && er) begin
        for (int i = 0; i < 8; i++) lanes.push_back(bf16_in[16*i +: 16]);
        accepted = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    // Reset and post-reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    zero_chk = 1'b1;
    step();

    // Plain word, full throughput.
    bf16_in = {16'h3C00, 16'h4049, 16'hFF80, 16'h7F80, 16'h8000, 16'h0000, 16'hC000, 16'h3F80};
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lit_en = 1'b1;
    lit_a = {32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'h3F80_0000};
    lit_b = lit_a;
    step();
    lit_en = 1'b1;
    lit_a = {32'h3C00_0000, 32'h4049_0000, 32'hFF80_0000, 32'h7F80_0000};
    lit_b = lit_a;
    step();
    step();

    // NaN quieting and flush-to-zero.
    bf16_in = {16'h1234, 16'h5678, 16'h7F80, 16'h0000, 16'hFFC0, 16'h8001, 16'h0001, 16'h7F81};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lit_en = 1'b1;
    lit_a = {32'hFFC0_0000, 32'h8001_0000, 32'h0001_0000, 32'h7FC1_0000};
    lit_b = {32'hFFC0_0000, 32'h8000_0000, 32'h0000_0000, 32'h7F81_0000};
    step();
    step();
    step();

    // Backpressure on beat 0; in_valid held high must be ignored.
    bf16_in = rand_word();
    in_valid = 1'b1;
    step();
    bf16_in = rand_word();
    out_ready = 1'b0;
    repeat (5) step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Back-to-back words with no bubble.
    in_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      bf16_in = rand_word();
      for (int t = 0; t < 8; t++) begin
        step();
        if (accepted) break;
      end
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Reset in the middle of a word.
    bf16_in = rand_word();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    zero_chk = 1'b1;
    step();
    bf16_in = rand_word();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      bf16_in   = rand_word();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
